btn_debounce: RTL and testbench

//   Input-side companion to the LED display drivers. Samples board push-buttons and
//   DIP switches (asynchronous, bouncing), synchronises and debounces them, and

---
 rtl/btn_debounce.sv | 181 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Synchronises and debounces button/switch inputs into clean levels and event pulses.
// Macros: SIM (tick every cycle), LONG_PRESS_EN (long-press hold counters).
module btn_debounce #(
   parameter int   CLK_IN_MHZ     = 125,
   parameter int   NUM_INPUTS     = 8,
   parameter int   DEBOUNCE_MS    = 20,
   parameter logic INPUT_POLARITY = 1'b0,
   parameter int   LONG_MS        = 1000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_INPUTS-1:0] btn_i,
   output logic [NUM_INPUTS-1:0] level_o,
   output logic [NUM_INPUTS-1:0] press_o,
   output logic [NUM_INPUTS-1:0] release_o,
   output logic [NUM_INPUTS-1:0] long_o
);

   localparam int CW = $clog2(DEBOUNCE_MS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

   typedef enum logic {
      ST_STABLE,
      ST_PENDING
   } state_t;

   if (CLK_IN_MHZ < 1 || DEBOUNCE_MS < 1 || LONG_MS < 1) begin : g_bad_param
      $error("btn_debounce: parameters must be >= 1");
   end

   logic tick;

`ifdef SIM
   assign tick = 1'b1;
`else
   localparam int PDIV = CLK_IN_MHZ * 1000;
   localparam int PW   = $clog2(PDIV);
   localparam logic [PW-1:0] PMAX = PW'(PDIV - 1);

   logic [PW-1:0] pre_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pre_q <= '0;
      end else if (pre_q == PMAX) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   assign tick = (pre_q == PMAX);
`endif

   // Synchronisers reset to the pin's inactive level.
   logic [NUM_INPUTS-1:0] sync1_q;
   logic [NUM_INPUTS-1:0] sync2_q;
   logic [NUM_INPUTS-1:0] raw;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= {NUM_INPUTS{~INPUT_POLARITY}};
         sync2_q <= {NUM_INPUTS{~INPUT_POLARITY}};
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   assign raw = ~(sync2_q ^ {NUM_INPUTS{INPUT_POLARITY}});

   state_t                state_q [NUM_INPUTS];
   state_t                state_d [NUM_INPUTS];
   logic [CW-1:0]         cnt_q   [NUM_INPUTS];
   logic [CW-1:0]         cnt_d   [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] level_q, level_d;
   logic [NUM_INPUTS-1:0] press_q, press_d;
   logic [NUM_INPUTS-1:0] rel_q, rel_d;
   logic [NUM_INPUTS-1:0] adv;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      adv     = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            ST_STABLE: begin
               cnt_d[i] = '0;
               if (raw[i] != level_q[i]) begin
                  state_d[i] = ST_PENDING;
                  adv[i]     = tick;
               end
            end
            ST_PENDING: begin
               if (raw[i] == level_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else begin
                  adv[i] = tick;
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = ST_STABLE;
            end
         endcase
         // Accept the change on the DEBOUNCE_MS-th disagreeing tick.
         if (adv[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = raw[i];
               press_d[i] = raw[i];
               rel_d[i]   = ~raw[i];
               cnt_d[i]   = '0;
               state_d[i] = ST_STABLE;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;

`ifdef LONG_PRESS_EN
   localparam int HW = $clog2(LONG_MS + 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);

   logic [HW-1:0]         hold_q [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] long_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            hold_q[i] <= '0;
         end
         long_q <= '0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            long_q[i] <= 1'b0;
            if (!level_q[i]) begin
               hold_q[i] <= '0;
            end else if (tick && hold_q[i] != HOLD_MAX) begin
               hold_q[i] <= hold_q[i] + 1'b1;
               long_q[i] <= (hold_q[i] == HOLD_LAST);
            end
         end
      end
   end

   assign long_o = long_q;
`else
   assign long_o = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (DEBOUNCE_MS=4, LONG_MS=10).
// Latency windows collapse to exact values when SIM makes every cycle a tick.
module tb_btn_debounce;

   localparam int N = 8;
`ifdef SIM
   localparam int TICK = 1;
`else
   localparam int TICK = 1000;
`endif
   localparam int LMIN = 3 + 3 * TICK;
   localparam int LMAX = 2 + 4 * TICK;
   localparam int LONGLAT = 10 * TICK;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] btn = '1;
   logic [N-1:0] level_o, press_o, release_o, long_o;

   int n_cmp = 0;
   int n_bad = 0;
   int both_cnt = 0;
   int long_cnt = 0;

   btn_debounce #(
      .CLK_IN_MHZ    (1),
      .NUM_INPUTS    (N),
      .DEBOUNCE_MS   (4),
      .INPUT_POLARITY(1'b0),
      .LONG_MS       (10)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .btn_i    (btn),
      .level_o  (level_o),
      .press_o  (press_o),
      .release_o(release_o),
      .long_o   (long_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if ((press_o & release_o) != '0) both_cnt++;
         if (long_o != '0) long_cnt++;
      end
   end

   task automatic wait_evt(input bit rel, input logic [N-1:0] mask,
                           input int bound, output int idx,
                           output logic [N-1:0] val);
      logic [N-1:0] s;
      idx = -1;
      val = '0;
      for (int i = 1; i <= bound && idx < 0; i++) begin
         @(negedge clk);
         s = rel ? release_o : press_o;
         if ((s & mask) != '0) begin
            idx = i;
            val = s;
         end
      end
   endtask

   task automatic test_reset;
      int idx;
      logic [N-1:0] v;
      @(negedge clk);
      rst = 1'b1;
      btn = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++; if (level_o !== 8'h00) begin n_bad++; $display("FAIL rst_level got %h exp 00", level_o); end
      n_cmp++; if (press_o !== 8'h00) begin n_bad++; $display("FAIL rst_press got %h exp 00", press_o); end
      n_cmp++; if (release_o !== 8'h00) begin n_bad++; $display("FAIL rst_release got %h exp 00", release_o); end
      n_cmp++; if (long_o !== 8'h00) begin n_bad++; $display("FAIL rst_long got %h exp 00", long_o); end
      rst = 1'b0;
      wait_evt(1'b0, 8'hFF, LMAX + 2, idx, v);
      n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL rst_press_all got %h exp ff", v); end
      n_cmp++; if (idx < LMIN || idx > LMAX) begin n_bad++; $display("FAIL rst_press_lat got %0d exp %0d..%0d", idx, LMIN, LMAX); end
      @(negedge clk);
      n_cmp++; if (press_o !== 8'h00) begin n_bad++; $display("FAIL rst_press_width got %h exp 00", press_o); end
      n_cmp++; if (level_o !== 8'hFF) begin n_bad++; $display("FAIL rst_level_all got %h exp ff", level_o); end
      btn = 8'hFF;
      wait_evt(1'b1, 8'hFF, LMAX + 2, idx, v);
      n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL rel_all got %h exp ff", v); end
   endtask

   task automatic test_press;
      int idx;
      logic [N-1:0] v;
      btn[0] = 1'b0;
      wait_evt(1'b0, 8'hFF, LMAX + 2, idx, v);
      n_cmp++; if (v !== 8'h01) begin n_bad++; $display("FAIL press0_val got %h exp 01", v); end
      n_cmp++; if (idx < LMIN || idx > LMAX) begin n_bad++; $display("FAIL press0_lat got %0d exp %0d..%0d", idx, LMIN, LMAX); end
      @(negedge clk);
      n_cmp++; if (press_o[0] !== 1'b0) begin n_bad++; $display("FAIL press0_width got %b exp 0", press_o[0]); end
      n_cmp++; if (level_o[0] !== 1'b1) begin n_bad++; $display("FAIL press0_level got %b exp 1", level_o[0]); end
      btn[0] = 1'b1;
      wait_evt(1'b1, 8'hFF, LMAX + 2, idx, v);
      n_cmp++; if (v !== 8'h01) begin n_bad++; $display("FAIL rel0_val got %h exp 01", v); end
   endtask

   task automatic test_glitch;
      int pc, idx;
      logic [N-1:0] v;
      logic [5:0] pat;
      pc = 0;
      btn[0] = 1'b0;
      repeat (3) begin @(negedge clk); if (press_o[0]) pc++; end
      btn[0] = 1'b1;
      repeat (LMAX + 4) begin @(negedge clk); if (press_o[0]) pc++; end
      n_cmp++; if (pc !== 0) begin n_bad++; $display("FAIL glitch_press got %0d exp 0", pc); end
      n_cmp++; if (level_o[0] !== 1'b0) begin n_bad++; $display("FAIL glitch_level got %b exp 0", level_o[0]); end
      pat = 6'b100100;
      for (int k = 0; k < 6; k++) begin
         btn[0] = pat[k];
         @(negedge clk);
         if (press_o[0]) pc++;
      end
      btn[0] = 1'b0;
      wait_evt(1'b0, 8'h01, LMAX + 2, idx, v);
      n_cmp++; if (pc !== 0) begin n_bad++; $display("FAIL bounce_early got %0d exp 0", pc); end
      n_cmp++; if (idx < LMIN || idx > LMAX) begin n_bad++; $display("FAIL bounce_lat got %0d exp %0d..%0d", idx, LMIN, LMAX); end
      repeat (LMAX) begin @(negedge clk); if (press_o[0]) pc++; end
      n_cmp++; if (pc !== 0) begin n_bad++; $display("FAIL bounce_extra got %0d exp 0", pc); end
      btn[0] = 1'b1;
      wait_evt(1'b1, 8'h01, LMAX + 2, idx, v);
   endtask

   task automatic test_release;
      int pc, idx;
      logic [N-1:0] v;
      btn[3] = 1'b0;
      wait_evt(1'b0, 8'h08, LMAX + 2, idx, v);
      btn[3] = 1'b1;
      pc = 0;
      idx = -1;
      for (int i = 1; i <= LMAX + 2; i++) begin
         @(negedge clk);
         if (press_o[3]) pc++;
         if (release_o[3] && idx < 0) idx = i;
      end
      n_cmp++; if (idx < LMIN || idx > LMAX) begin n_bad++; $display("FAIL rel3_lat got %0d exp %0d..%0d", idx, LMIN, LMAX); end
      n_cmp++; if (pc !== 0) begin n_bad++; $display("FAIL rel3_press got %0d exp 0", pc); end
      n_cmp++; if (level_o[3] !== 1'b0) begin n_bad++; $display("FAIL rel3_level got %b exp 0", level_o[3]); end
   endtask

   task automatic test_simul;
      int idx;
      logic [N-1:0] v;
      btn = 8'h7E;
      wait_evt(1'b0, 8'hFF, LMAX + 2, idx, v);
      n_cmp++; if (v !== 8'h81) begin n_bad++; $display("FAIL simul_press got %h exp 81", v); end
      n_cmp++; if (idx < LMIN || idx > LMAX) begin n_bad++; $display("FAIL simul_lat got %0d exp %0d..%0d", idx, LMIN, LMAX); end
      btn = 8'hFF;
      wait_evt(1'b1, 8'hFF, LMAX + 2, idx, v);
      n_cmp++; if (v !== 8'h81) begin n_bad++; $display("FAIL simul_rel got %h exp 81", v); end
   endtask

   task automatic test_long;
      int idx, first, nl;
      logic [N-1:0] v;
      btn[2] = 1'b0;
      wait_evt(1'b0, 8'h04, LMAX + 2, idx, v);
      first = -1;
      nl = 0;
      for (int i = 1; i <= LONGLAT + 2 * TICK + 2; i++) begin
         @(negedge clk);
         if (long_o[2]) begin
            nl++;
            if (first < 0) first = i;
         end
      end
`ifdef LONG_PRESS_EN
      n_cmp++; if (first !== LONGLAT) begin n_bad++; $display("FAIL long_lat got %0d exp %0d", first, LONGLAT); end
      n_cmp++; if (nl !== 1) begin n_bad++; $display("FAIL long_once got %0d exp 1", nl); end
`else
      n_cmp++; if (nl !== 0) begin n_bad++; $display("FAIL long_off got %0d exp 0", nl); end
`endif
      btn[2] = 1'b1;
      wait_evt(1'b1, 8'h04, LMAX + 2, idx, v);
      btn[2] = 1'b0;
      wait_evt(1'b0, 8'h04, LMAX + 2, idx, v);
      btn[2] = 1'b1;
      nl = 0;
      repeat (LONGLAT + 5) begin @(negedge clk); if (long_o[2]) nl++; end
      n_cmp++; if (nl !== 0) begin n_bad++; $display("FAIL long_short got %0d exp 0", nl); end
      n_cmp++; if (level_o[2] !== 1'b0) begin n_bad++; $display("FAIL long_rel_level got %b exp 0", level_o[2]); end
   endtask

   task automatic test_reset_pending;
      int ec;
      btn[5] = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (press_o[5] !== 1'b0) begin n_bad++; $display("FAIL pend_early got %b exp 0", press_o[5]); end
      rst = 1'b1;
      btn = 8'hFF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ec = 0;
      repeat (LMAX + 4) begin
         @(negedge clk);
         if ((press_o | release_o) != '0) ec++;
      end
      n_cmp++; if (ec !== 0) begin n_bad++; $display("FAIL pend_event got %0d exp 0", ec); end
      n_cmp++; if (level_o !== 8'h00) begin n_bad++; $display("FAIL pend_level got %h exp 00", level_o); end
   endtask

   initial begin
      int exp_long;
      test_reset();
      test_press();
      test_glitch();
      test_release();
      test_simul();
      test_long();
      test_reset_pending();
`ifdef LONG_PRESS_EN
      exp_long = 1;
`else
      exp_long = 0;
`endif
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL press_and_release got %0d exp 0", both_cnt); end
      n_cmp++; if (long_cnt !== exp_long) begin n_bad++; $display("FAIL long_total got %0d exp %0d", long_cnt, exp_long); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
